// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_A    = 4'h0;
  localparam logic [3:0] OP_B    = 4'h1;
  localparam logic [3:0] OP_NOTA = 4'h2;
  localparam logic [3:0] OP_NOTB = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_ADC  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_ZERO = 4'h8;
  localparam logic [3:0] OP_ONE  = 4'h9;
  localparam logic [3:0] OP_ONES = 4'hA;
  localparam logic [3:0] OP_CLC  = 4'hB;
  localparam logic [3:0] OP_SEC  = 4'hC;
  localparam logic [3:0] OP_SUB  = 4'hD;
  localparam logic [3:0] OP_SHL  = 4'hE;
  localparam logic [3:0] OP_SHR  = 4'hF;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative one-bit-per-cycle logical shifter: work register plus down-counter.
// Exposes the value and bit-out of the current step so the caller can capture
// the final result on the step where the counter runs out.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_right,
  input  logic [WIDTH-1:0] i_a,
  input  logic [SHW-1:0]   i_n,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_result,
  output logic             o_bit_out,
  output logic             o_last_step
);

  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic             r_right;

  logic [WIDTH-1:0] w_shifted;
  logic             w_bit_out;

  // One-bit shift of the work register and the bit that falls off the end.
  always_comb begin
    w_shifted = r_work;
    w_bit_out = 1'b0;
    if (r_right) begin
      w_shifted = {1'b0, r_work[WIDTH-1:1]};
      w_bit_out = r_work[0];
    end else begin
      w_shifted = {r_work[WIDTH-2:0], 1'b0};
      w_bit_out = r_work[WIDTH-1];
    end
  end

  // Work register, direction and counter: load on accept, advance on each step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_work  <= '0;
      r_cnt   <= '0;
      r_right <= 1'b0;
    end else if (i_load) begin
      r_work  <= i_a;
      r_cnt   <= i_n;
      r_right <= i_right;
    end else if (i_step && (r_cnt != '0)) begin
      r_work <= w_shifted;
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  assign o_result    = w_shifted;
  assign o_bit_out   = w_bit_out;
  assign o_last_step = (r_cnt == {{(SHW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with persistent carry, zero flag and iterative shifts.
// Single-cycle ops complete at the accept edge; shifts by n>=1 take n more edges.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z,
  output logic             cy,
  output logic             zf,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  logic [WIDTH-1:0] r_z;
  logic             r_cy;
  logic             r_zf;
  logic             r_done;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_z_nxt;
  logic             w_cy_nxt;
  logic             w_zf_nxt;
  logic             w_done_nxt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_core_z;
  logic             w_core_cy;
  logic             w_core_wz;

  logic [SHW-1:0]   w_n;
  logic             w_is_shift;
  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_sh_result;
  logic             w_sh_bit_out;
  logic             w_sh_last;

  assign w_n        = b[SHW-1:0];
  assign w_is_shift = (op == OP_SHL) || (op == OP_SHR);

  alu_shift_unit #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_right     (op == OP_SHR),
    .i_a         (a),
    .i_n         (w_n),
    .i_step      (w_step),
    .o_result    (w_sh_result),
    .o_bit_out   (w_sh_bit_out),
    .o_last_step (w_sh_last)
  );

  // Single-cycle core: result, carry and whether z is written for the current opcode.
  always_comb begin
    w_sum     = '0;
    w_core_z  = r_z;
    w_core_cy = r_cy;
    w_core_wz = 1'b1;
    unique case (op)
      OP_A:    w_core_z = a;
      OP_B:    w_core_z = b;
      OP_NOTA: w_core_z = ~a;
      OP_NOTB: w_core_z = ~b;
      OP_ADD: begin
        w_sum     = {1'b0, a} + {1'b0, b};
        w_core_z  = w_sum[WIDTH-1:0];
        w_core_cy = w_sum[WIDTH];
      end
      OP_ADC: begin
        w_sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, r_cy};
        w_core_z  = w_sum[WIDTH-1:0];
        w_core_cy = w_sum[WIDTH];
      end
      OP_OR:   w_core_z = a | b;
      OP_AND:  w_core_z = a & b;
      OP_ZERO: w_core_z = '0;
      OP_ONE:  w_core_z = {{(WIDTH-1){1'b0}}, 1'b1};
      OP_ONES: w_core_z = '1;
      OP_CLC: begin
        w_core_cy = 1'b0;
        w_core_wz = 1'b0;
      end
      OP_SEC: begin
        w_core_cy = 1'b1;
        w_core_wz = 1'b0;
      end
      // Carry set means no borrow.
      OP_SUB: begin
        w_sum     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        w_core_z  = w_sum[WIDTH-1:0];
        w_core_cy = w_sum[WIDTH];
      end
      // Only the n=0 case resolves here; n>=1 goes through the shift unit.
      OP_SHL, OP_SHR: w_core_z = a;
      default: ;
    endcase
  end

  // FSM next-state, flag/result updates and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_z_nxt     = r_z;
    w_cy_nxt    = r_cy;
    w_zf_nxt    = r_zf;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          if (w_is_shift && (w_n != '0)) begin
            w_load      = 1'b1;
            w_state_nxt = SHIFT;
          end else begin
            w_z_nxt    = w_core_z;
            w_cy_nxt   = w_core_cy;
            w_zf_nxt   = w_core_wz ? (w_core_z == '0) : r_zf;
            w_done_nxt = 1'b1;
          end
        end
      end
      SHIFT: begin
        w_step = 1'b1;
        if (w_sh_last) begin
          w_z_nxt     = w_sh_result;
          w_cy_nxt    = w_sh_bit_out;
          w_zf_nxt    = (w_sh_result == '0);
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, result and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_z     <= '0;
      r_cy    <= 1'b0;
      r_zf    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_z     <= w_z_nxt;
      r_cy    <= w_cy_nxt;
      r_zf    <= w_zf_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign z    = r_z;
  assign cy   = r_cy;
  assign zf   = r_zf;
  assign done = r_done;
  assign busy = (r_state == SHIFT);

endmodule
